fpu_writeback: RTL and testbench
================================

# fpu_writeback

Writeback and retire stage directly downstream of the FPU execution stage. Holds an in-order queue of destination tags for issued FPU instructions and matches each completion pulse from execution to the oldest tag. It then drives a one-cycle write to the FP register file (16-bit bfloat16) or to the integer GPR file. It also keeps the sticky `fflags` exception accumulator for the CSR unit.

## Interface
Parameters:
- `DEPTH`, 4: tag-queue entries (power of two, ≥2).
- `FLEN`, 16: FP result width.
- `XLEN`, 32: integer result width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `issue_valid`  in  1  FPU instruction issued to execution this cycle.
- `issue_rd`  in  5  destination register index.
- `issue_is_int`  in  1  1 = result goes to GPR (compare/convert/move); 0 = FP register file.
- `issue_ready`  out  1  queue not full. Issue is accepted only when `issue_valid & issue_ready`.
- `fpu_complete`  in  1  FP result valid pulse.
- `fpu_result_1`  in  FLEN  FP result.
- `fpu_complete_rd`  in  1  integer result valid pulse.
- `fpu_result_rd`  in  XLEN  integer result.
- `sflags`  in  5  exception flags of the completing op, `{NV,DZ,OF,UF,NX}`.
- `IV_exception`  in  1  invalid-operation indication; ORed into NV.
- `fflags_clr`  in  1  CSR write clearing the accumulator.
- `frf_we`  out  1  FP register file write enable.
- `frf_waddr`  out  5  FP register file write address.
- `frf_wdata`  out  FLEN  FP register file write data.
- `gpr_we`  out  1  GPR write enable.
- `gpr_waddr`  out  5  GPR write address.
- `gpr_wdata`  out  XLEN  GPR write data.
- `fflags`  out  5  sticky accumulated flags.
- `busy`  out  1  queue non-empty.
- `err_spurious`  out  1  one-cycle pulse on an illegal completion.

## Operation
Tag queue:
- Circular FIFO of `{rd, is_int}` with read pointer, write pointer and an occupancy count of width clog2(DEPTH)+1.
- Pointers wrap modulo DEPTH.
- `issue_ready = (count != DEPTH)`. When the queue is full, a same-cycle pop does not free a slot for a push.

Completion (`cmp = fpu_complete | fpu_complete_rd`):
- Legal completion requires all of the following:
  - queue non-empty at the start of the cycle;
  - exactly one of the two pulses high;
  - pulse type matches the head entry (`fpu_complete` ↔ `is_int=0`, `fpu_complete_rd` ↔ `is_int=1`).
- Legal completion:
  - pop the head;
  - register the write to the matching file with head `rd` and the corresponding data;
  - `fflags <= fflags | sflags | {IV_exception,4'b0}`.
- GPR destination `rd=0`: `gpr_we` is suppressed, but the pop and flag accumulation still happen. FP `f0` is writable.
- Illegal completion (empty queue, both pulses high, or type mismatch):
  - no pop, no write, no flag update;
  - `err_spurious` pulses one cycle later.
- A completion in the same cycle as an issue into an empty queue is illegal. The tag issued that cycle is still pushed.
- Simultaneous legal pop and push when not full: count unchanged, both pointers advance.
- `fflags_clr` together with a legal completion: `fflags <=` the new completion flags only (clear first, then accumulate). `fflags_clr` alone: `fflags <= 0`.

## Timing
- Reset values: `issue_ready=1`, `busy=0`, all write enables 0, all addresses and data 0, `fflags=0`, `err_spurious=0`, queue empty.
- Reset asserted mid-operation flushes the queue and discards any pending write on the next edge.
- Latency: a completion sampled at edge N produces write enable, address and data valid during cycle N+1, for exactly one cycle. `fflags` is updated at the same edge.
- Throughput: one completion per cycle, back-to-back completions allowed.
- `issue_ready` and `busy` reflect registered state, so there is no combinational path from the completion inputs.

## Structure
- Package `fpu_wb_pkg` holds:
  - flag bit index constants `FLAG_NV=4, FLAG_DZ=3, FLAG_OF=2, FLAG_UF=1, FLAG_NX=0`;
  - the tag-entry typedef `{logic [4:0] rd; logic is_int;}`;
  - the constant `X0 = 5'd0`.
- Sub-module `fpu_tag_fifo` (parameter DEPTH) contains the circular queue, pointers, count, full and empty. The top level holds the match/check logic, the write registers and `fflags`.

## Test plan
- Issue FP tag rd=3, then `fpu_complete` with result 16'h3F80 and `sflags=0` two cycles later → `frf_we=1`, `frf_waddr=3`, `frf_wdata=16'h3F80` for exactly one cycle; `busy` returns to 0.
- Issue int tags rd=5 and rd=0, then two `fpu_complete_rd` pulses with 32'h1 and 32'h7 → `gpr_we` high only for rd=5 with data 32'h1; queue empty afterwards.
- Issue 4 tags without completions → `issue_ready=0`; a fifth `issue_valid` is ignored. Complete all 4 with pointer wrap → in-order addresses 0..3.
- Completion sequence:
  - `sflags=5'b00001`, then `sflags=5'b00100` → `fflags=5'b00101`;
  - then `IV_exception=1` → `fflags=5'b10101`;
  - then `fflags_clr` with a completion carrying `sflags=5'b00010` → `fflags=5'b00010`.
- Illegal completions → `err_spurious` pulse, no write, queue unchanged:
  - `fpu_complete` on an empty queue;
  - `fpu_complete_rd` when the head is an FP tag;
  - both pulses high together.
- Assert `rst` with 3 tags queued and a completion in flight → all outputs 0 next cycle; a later completion raises `err_spurious`.

Source files
------------

// File: rtl/fpu_wb_pkg.sv
// Shared constants and the tag-queue entry type for the FPU writeback stage.
package fpu_wb_pkg;
   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   localparam logic [4:0] X0 = 5'd0;

   typedef struct packed {
      logic [4:0] rd;
      logic       is_int;
   } tag_t;
endpackage

// File: rtl/fpu_tag_fifo.sv
// In-order circular queue of destination tags for issued FPU instructions.
module fpu_tag_fifo
   import fpu_wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  tag_t push_tag,
   input  logic pop,
   output tag_t head,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   tag_t          mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          push_ok, pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   // full is taken from registered count, so a same-cycle pop never frees a slot
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_tag;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/fpu_writeback.sv
// FPU writeback/retire: matches completions to the oldest tag, drives one-cycle
// register-file writes and accumulates sticky fflags.
module fpu_writeback
   import fpu_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int FLEN  = 16,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic            issue_is_int,
   output logic            issue_ready,
   input  logic            fpu_complete,
   input  logic [FLEN-1:0] fpu_result_1,
   input  logic            fpu_complete_rd,
   input  logic [XLEN-1:0] fpu_result_rd,
   input  logic [4:0]      sflags,
   input  logic            IV_exception,
   input  logic            fflags_clr,
   output logic            frf_we,
   output logic [4:0]      frf_waddr,
   output logic [FLEN-1:0] frf_wdata,
   output logic            gpr_we,
   output logic [4:0]      gpr_waddr,
   output logic [XLEN-1:0] gpr_wdata,
   output logic [4:0]      fflags,
   output logic            busy,
   output logic            err_spurious
);
   tag_t       head, push_tag;
   logic       full, empty, cmp, legal, to_gpr, to_frf;
   logic [4:0] new_flags;

   assign push_tag = '{rd: issue_rd, is_int: issue_is_int};

   fpu_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (issue_valid),
      .push_tag (push_tag),
      .pop      (legal),
      .head     (head),
      .full     (full),
      .empty    (empty)
   );

   assign issue_ready = ~full;
   assign busy        = ~empty;

   assign cmp    = fpu_complete | fpu_complete_rd;
   // exactly one pulse, and its kind must agree with the oldest tag
   assign legal  = ~empty & (fpu_complete ^ fpu_complete_rd) & (fpu_complete_rd == head.is_int);
   assign to_frf = legal & ~head.is_int;
   assign to_gpr = legal & head.is_int & (head.rd != X0);

   always_comb begin
      new_flags          = sflags;
      new_flags[FLAG_NV] = sflags[FLAG_NV] | IV_exception;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frf_we       <= 1'b0;
         frf_waddr    <= '0;
         frf_wdata    <= '0;
         gpr_we       <= 1'b0;
         gpr_waddr    <= '0;
         gpr_wdata    <= '0;
         fflags       <= '0;
         err_spurious <= 1'b0;
      end else begin
         frf_we       <= to_frf;
         frf_waddr    <= to_frf ? head.rd : '0;
         frf_wdata    <= to_frf ? fpu_result_1 : '0;
         gpr_we       <= to_gpr;
         gpr_waddr    <= to_gpr ? head.rd : '0;
         gpr_wdata    <= to_gpr ? fpu_result_rd : '0;
         err_spurious <= cmp & ~legal;
         // a clear coinciding with a completion keeps only that completion's flags
         if (fflags_clr)  fflags <= legal ? new_flags : '0;
         else if (legal)  fflags <= fflags | new_flags;
      end
   end
endmodule

// File: tb/tb_fpu_writeback.sv
// Directed bench for fpu_writeback with a queue-based reference model.
module tb_fpu_writeback;
   import fpu_wb_pkg::*;
   localparam int DEPTH = 4;

   logic        clk = 0, rst = 1;
   logic        issue_valid = 0, issue_is_int = 0, issue_ready;
   logic [4:0]  issue_rd = 0;
   logic        fpu_complete = 0, fpu_complete_rd = 0;
   logic [15:0] fpu_result_1 = 0;
   logic [31:0] fpu_result_rd = 0;
   logic [4:0]  sflags = 0;
   logic        IV_exception = 0, fflags_clr = 0;
   logic        frf_we, gpr_we, busy, err_spurious;
   logic [4:0]  frf_waddr, gpr_waddr, fflags;
   logic [15:0] frf_wdata;
   logic [31:0] gpr_wdata;

   int n_cmp = 0, n_bad = 0;
   bit mon_en = 0;

   always #5 clk = ~clk;

   fpu_writeback #(.DEPTH(DEPTH), .FLEN(16), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_is_int(issue_is_int), .issue_ready(issue_ready),
      .fpu_complete(fpu_complete), .fpu_result_1(fpu_result_1),
      .fpu_complete_rd(fpu_complete_rd), .fpu_result_rd(fpu_result_rd),
      .sflags(sflags), .IV_exception(IV_exception), .fflags_clr(fflags_clr),
      .frf_we(frf_we), .frf_waddr(frf_waddr), .frf_wdata(frf_wdata),
      .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
      .fflags(fflags), .busy(busy), .err_spurious(err_spurious)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of outstanding tags, outputs recomputed per edge.
   tag_t        q[$];
   logic        e_frf_we, e_gpr_we, e_err;
   logic [4:0]  e_frf_waddr, e_gpr_waddr, e_fflags;
   logic [15:0] e_frf_wdata;
   logic [31:0] e_gpr_wdata;

   always @(posedge clk) begin
      int   n0;
      bit   ok;
      tag_t h;
      if (rst) begin
         q.delete();
         e_frf_we = 0; e_gpr_we = 0; e_err = 0; e_fflags = 0;
      end else begin
         n0 = q.size();
         ok = 0;
         if (n0 > 0) begin
            h  = q[0];
            ok = (fpu_complete != fpu_complete_rd) && (fpu_complete_rd == h.is_int);
         end
         e_err       = (fpu_complete || fpu_complete_rd) && !ok;
         e_frf_we    = ok && !h.is_int;
         e_frf_waddr = h.rd;
         e_frf_wdata = fpu_result_1;
         e_gpr_we    = ok && h.is_int && h.rd != 0;
         e_gpr_waddr = h.rd;
         e_gpr_wdata = fpu_result_rd;
         if (fflags_clr) e_fflags = 0;
         if (ok) begin
            e_fflags = e_fflags | sflags | {IV_exception, 4'b0};
            void'(q.pop_front());
         end
         if (issue_valid && n0 < DEPTH) q.push_back('{rd: issue_rd, is_int: issue_is_int});
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("m_issue_ready", issue_ready, q.size() != DEPTH);
         chk("m_busy", busy, q.size() != 0);
         chk("m_frf_we", frf_we, e_frf_we);
         chk("m_gpr_we", gpr_we, e_gpr_we);
         chk("m_err", err_spurious, e_err);
         chk("m_fflags", fflags, e_fflags);
         if (e_frf_we) begin
            chk("m_frf_waddr", frf_waddr, e_frf_waddr);
            chk("m_frf_wdata", frf_wdata, e_frf_wdata);
         end
         if (e_gpr_we) begin
            chk("m_gpr_waddr", gpr_waddr, e_gpr_waddr);
            chk("m_gpr_wdata", gpr_wdata, e_gpr_wdata);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 0; fpu_complete = 0; fpu_complete_rd = 0;
      sflags = 0; IV_exception = 0; fflags_clr = 0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic is_int);
      issue_valid = 1; issue_rd = rd; issue_is_int = is_int;
      cyc();
      issue_valid = 0;
   endtask

   initial begin
      cyc(); mon_en = 1; cyc();
      rst = 0;
      chk("rst_ready", issue_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_fflags", fflags, 0);
      chk("rst_we", {frf_we, gpr_we, err_spurious}, 0);

      // single FP writeback
      issue(5'd3, 0);
      cyc();
      fpu_complete = 1; fpu_result_1 = 16'h3F80;
      cyc(); idle();
      chk("fp_we", frf_we, 1);
      chk("fp_waddr", frf_waddr, 3);
      chk("fp_wdata", frf_wdata, 16'h3F80);
      chk("fp_busy", busy, 0);
      cyc();
      chk("fp_we_once", frf_we, 0);

      // integer writebacks, x0 suppressed
      issue(5'd5, 1);
      issue(5'd0, 1);
      fpu_complete_rd = 1; fpu_result_rd = 32'h1;
      cyc();
      chk("gpr_we5", gpr_we, 1);
      chk("gpr_waddr5", gpr_waddr, 5);
      chk("gpr_wdata5", gpr_wdata, 32'h1);
      fpu_result_rd = 32'h7;
      cyc(); idle();
      chk("gpr_we0", gpr_we, 0);
      chk("gpr_empty", busy, 0);

      // fill, overflow attempt, drain across pointer wrap
      for (int i = 0; i < 4; i++) issue(5'(i), 0);
      chk("full_ready", issue_ready, 0);
      issue(5'd9, 0);
      chk("full_busy", busy, 1);
      for (int i = 0; i < 4; i++) begin
         fpu_complete = 1; fpu_result_1 = 16'(16'h100 + i);
         cyc();
         chk("wrap_waddr", frf_waddr, i);
         chk("wrap_we", frf_we, 1);
      end
      idle();
      cyc();
      chk("wrap_empty", busy, 0);
      chk("wrap_ready", issue_ready, 1);

      // flag accumulation
      for (int i = 1; i <= 4; i++) issue(5'(i), 0);
      fpu_complete = 1; sflags = 5'b00001; cyc();
      sflags = 5'b00100; cyc();
      chk("flags_acc", fflags, 5'b00101);
      sflags = 0; IV_exception = 1; cyc();
      chk("flags_iv", fflags, 5'b10101);
      IV_exception = 0; fflags_clr = 1; sflags = 5'b00010; cyc();
      idle();
      chk("flags_clr", fflags, 5'b00010);
      cyc();

      // illegal completions
      fpu_complete = 1; cyc(); idle();
      chk("spur_empty", err_spurious, 1);
      chk("spur_empty_we", frf_we, 0);
      cyc();
      chk("spur_pulse", err_spurious, 0);
      issue(5'd7, 0);
      fpu_complete_rd = 1; cyc(); idle();
      chk("spur_type", err_spurious, 1);
      chk("spur_type_we", gpr_we, 0);
      chk("spur_type_busy", busy, 1);
      fpu_complete = 1; fpu_complete_rd = 1; cyc(); idle();
      chk("spur_both", err_spurious, 1);
      chk("spur_both_busy", busy, 1);
      fpu_complete = 1; cyc(); idle();
      chk("after_spur_waddr", frf_waddr, 7);
      chk("after_spur_err", err_spurious, 0);
      cyc();
      // completion alongside an issue into an empty queue
      issue_valid = 1; issue_rd = 5'd2; issue_is_int = 0; fpu_complete = 1;
      cyc(); idle();
      chk("spur_sameissue", err_spurious, 1);
      chk("sameissue_busy", busy, 1);
      fpu_complete = 1; cyc(); idle();
      chk("sameissue_waddr", frf_waddr, 2);

      // reset mid-operation
      issue(5'd10, 0); issue(5'd11, 0); issue(5'd12, 0); issue(5'd13, 0);
      fpu_complete = 1; sflags = 5'b01000; cyc();
      rst = 1; cyc(); idle();
      chk("mrst_we", {frf_we, gpr_we}, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_fflags", fflags, 0);
      chk("mrst_addr", {frf_waddr, gpr_waddr}, 0);
      chk("mrst_ready", issue_ready, 1);
      rst = 0;
      fpu_complete = 1; cyc(); idle();
      chk("mrst_spur", err_spurious, 1);
      cyc(); cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
